// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter
//   Shares one synchronous sprite ROM read port among NUM_REQ sprite drawers
//   (Pac-Man, four ghosts, food/power-up/lives). It makes a round-robin grant
//   each cycle and issues at most one ROM read per cycle. The ROM data comes
//   back a fixed two cycles after acceptance and is tagged with the index of
//   the requester.
//
//   Optional feature macro: SPRITE_ARB_PACMAN_PRIO_EN
//     When it is defined, requester 0 wins whenever it requests. Its grants
//     leave the round-robin pointer alone, and requesters 1..NUM_REQ-1 keep
//     round-robin among themselves.
//
// Ports
//   clock, reset   system clock, synchronous active-high reset
//   req            per-requester read request, held until granted
//   req_sprite     packed sprite selects, slice i = requester i
//   req_addr       packed pixel addresses, slice i = requester i
//   gnt            one-hot combinational grant; accepted on the next edge
//   pause          blocks new grants; in-flight reads still complete
//   rom_sprite     registered sprite select to the ROM bank
//   rom_addr       registered pixel address to the ROM bank
//   rom_q          ROM bank data, valid one cycle after rom_addr
//   rsp_valid      response valid
//   rsp_id         requester index of the response
//   rsp_data       palette index (rom_q when valid, else 0)
//   busy           a read is in flight
module sprite_rom_arbiter #(
    parameter int NUM_REQ = 6,
    parameter int ADDR_W  = 8,
    parameter int SPR_W   = 5,
    parameter int DATA_W  = 2,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*SPR_W-1:0]  req_sprite,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    input  logic                      pause,
    output logic [SPR_W-1:0]          rom_sprite,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_q,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      busy
);

    // Packed per-requester views of the flat slice buses.
    logic [NUM_REQ-1:0][SPR_W-1:0]  spr_arr;
    logic [NUM_REQ-1:0][ADDR_W-1:0] addr_arr;
    assign spr_arr  = req_sprite;
    assign addr_arr = req_addr;

    logic [ID_W-1:0]    rr_ptr;
    logic [NUM_REQ-1:0] rr_req;   // requesters that take part in round-robin
    logic               pac_win;  // requester 0 overrides round-robin
    logic               accept;
    logic               pac_hit;
    logic [ID_W-1:0]    gidx;

    // vld_pipe[1] = issue stage (S1), vld_pipe[2] = response stage (S2)
    logic [2:1]         vld_pipe;
    logic [ID_W-1:0]    s1_id;
    logic [ID_W-1:0]    s2_id;

`ifdef SPRITE_ARB_PACMAN_PRIO_EN
    always_comb begin
        rr_req    = req;
        rr_req[0] = 1'b0;
        pac_win   = req[0];
    end
`else
    always_comb begin
        rr_req  = req;
        pac_win = 1'b0;
    end
`endif

    // Scan from rr_ptr upward. Take the first requester found, wrapping
    // modulo NUM_REQ (which may not be a power of two).
    always_comb begin : arb
        int c;
        logic [ID_W-1:0] cidx;
        c       = 0;
        cidx    = '0;
        accept  = 1'b0;
        pac_hit = 1'b0;
        gidx    = '0;
        gnt     = '0;
        if (!pause) begin
            if (pac_win) begin
                accept  = 1'b1;
                pac_hit = 1'b1;
            end else begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    c = int'(rr_ptr) + k;
                    if (c >= NUM_REQ) c = c - NUM_REQ;
                    cidx = ID_W'(c);
                    if (!accept && rr_req[cidx]) begin
                        accept = 1'b1;
                        gidx   = cidx;
                    end
                end
            end
        end
        if (accept) gnt[gidx] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr     <= '0;
            rom_sprite <= '0;
            rom_addr   <= '0;
            vld_pipe   <= '0;
            s1_id      <= '0;
            s2_id      <= '0;
        end else begin
            // A grant to Pac-Man in priority mode does not move the pointer.
            if (accept && !pac_hit)
                rr_ptr <= (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
            if (accept) begin
                rom_sprite <= spr_arr[gidx];
                rom_addr   <= addr_arr[gidx];
                s1_id      <= gidx;
            end
            vld_pipe <= {vld_pipe[1], accept};
            s2_id    <= s1_id;
        end
    end

    assign rsp_valid = vld_pipe[2];
    assign rsp_id    = s2_id;
    assign rsp_data  = vld_pipe[2] ? rom_q : '0;
    assign busy      = |vld_pipe;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed, table-driven bench for sprite_rom_arbiter (NUM_REQ=6).
// Each row holds the inputs for one cycle and the expected outputs:
//   gnt is checked before the edge;
//   rsp_valid/rsp_id/rsp_data/busy/rom_* are checked 1 ns after the edge.
module tb_sprite_rom_arbiter;

    localparam int N  = 6;
    localparam int AW = 8;
    localparam int SW = 5;
    localparam int DW = 2;
    localparam int IW = $clog2(N);

    logic              clock = 1'b0;
    logic              reset;
    logic [N-1:0]      req;
    logic [N*SW-1:0]   req_sprite;
    logic [N*AW-1:0]   req_addr;
    logic [N-1:0]      gnt;
    logic              pause;
    logic [SW-1:0]     rom_sprite;
    logic [AW-1:0]     rom_addr;
    logic [DW-1:0]     rom_q;
    logic              rsp_valid;
    logic [IW-1:0]     rsp_id;
    logic [DW-1:0]     rsp_data;
    logic              busy;

    sprite_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .SPR_W(SW), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset), .req(req), .req_sprite(req_sprite),
        .req_addr(req_addr), .gnt(gnt), .pause(pause), .rom_sprite(rom_sprite),
        .rom_addr(rom_addr), .rom_q(rom_q), .rsp_valid(rsp_valid),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clock = ~clock;

    // ROM model: registered output one cycle after the address.
    function automatic logic [DW-1:0] rom_f(input logic [SW-1:0] s, input logic [AW-1:0] a);
        return a[1:0] ^ s[1:0] ^ a[5:4];
    endfunction

    always_ff @(posedge clock) rom_q <= rom_f(rom_sprite, rom_addr);

    logic [SW-1:0] spr_tab [N];
    logic [AW-1:0] addr_tab[N];

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic         pause;
        logic [N-1:0] exp_gnt;
        logic         exp_vld;
        int           exp_id;
        logic         exp_busy;
    } vec_t;

    vec_t vecs[$];
    int   passed = 0;
    int   total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic vec_t mk(input logic rst, input logic [N-1:0] r, input logic p,
                                input logic [N-1:0] g, input logic v, input int id,
                                input logic b);
        vec_t t;
        t.rst = rst; t.req = r; t.pause = p; t.exp_gnt = g;
        t.exp_vld = v; t.exp_id = id; t.exp_busy = b;
        return t;
    endfunction

    initial begin
        for (int i = 0; i < N; i++) begin
            spr_tab[i]  = SW'(3 + i);
            addr_tab[i] = AW'(8'h45 + 8'h11 * i);
            req_sprite[i*SW +: SW] = spr_tab[i];
            req_addr[i*AW +: AW]   = addr_tab[i];
        end
        reset = 1'b1; req = '0; pause = 1'b0;

`ifndef SPRITE_ARB_PACMAN_PRIO_EN
        // reset, single request from Pac-Man
        vecs.push_back(mk(1, 6'b000000, 0, 6'b000000, 0, 0, 0));
        vecs.push_back(mk(0, 6'b000001, 0, 6'b000001, 0, 0, 1));
        vecs.push_back(mk(0, 6'b000000, 0, 6'b000000, 1, 0, 1));
        vecs.push_back(mk(0, 6'b000000, 0, 6'b000000, 0, 0, 0));
        // reset, then all requesters for 12 cycles
        vecs.push_back(mk(1, 6'b000000, 0, 6'b000000, 0, 0, 0));
        for (int k = 0; k < 12; k++)
            vecs.push_back(mk(0, 6'b111111, 0, N'(1) << (k % N), k >= 1, (k + N - 1) % N, 1));
        vecs.push_back(mk(0, 6'b000000, 0, 6'b000000, 1, 5, 1));
        vecs.push_back(mk(0, 6'b000000, 0, 6'b000000, 0, 0, 0));
        // move rr_ptr to 3, then 100100 -> 5 then 2
        vecs.push_back(mk(0, 6'b000100, 0, 6'b000100, 0, 0, 1));
        vecs.push_back(mk(0, 6'b100100, 0, 6'b100000, 1, 2, 1));
        vecs.push_back(mk(0, 6'b000100, 0, 6'b000100, 1, 5, 1));
        vecs.push_back(mk(0, 6'b000000, 0, 6'b000000, 1, 2, 1));
        vecs.push_back(mk(0, 6'b000000, 0, 6'b000000, 0, 0, 0));
        // two back-to-back grants (3, 4), then pause with req 000010
        vecs.push_back(mk(0, 6'b001000, 0, 6'b001000, 0, 0, 1));
        vecs.push_back(mk(0, 6'b010000, 0, 6'b010000, 1, 3, 1));
        vecs.push_back(mk(0, 6'b000010, 1, 6'b000000, 1, 4, 1));
        vecs.push_back(mk(0, 6'b000010, 1, 6'b000000, 0, 0, 0));
        vecs.push_back(mk(0, 6'b000010, 1, 6'b000000, 0, 0, 0));
        vecs.push_back(mk(0, 6'b000010, 1, 6'b000000, 0, 0, 0));
        vecs.push_back(mk(0, 6'b000010, 0, 6'b000010, 0, 0, 1));
        vecs.push_back(mk(0, 6'b000000, 0, 6'b000000, 1, 1, 1));
        vecs.push_back(mk(0, 6'b000000, 0, 6'b000000, 0, 0, 0));
        // accept, then reset the next cycle: the read is dropped
        vecs.push_back(mk(0, 6'b000001, 0, 6'b000001, 0, 0, 1));
        vecs.push_back(mk(1, 6'b000000, 0, 6'b000000, 0, 0, 0));
        vecs.push_back(mk(0, 6'b000000, 0, 6'b000000, 0, 0, 0));
        vecs.push_back(mk(0, 6'b000000, 0, 6'b000000, 0, 0, 0));
`else
        vecs.push_back(mk(1, 6'b000000, 0, 6'b000000, 0, 0, 0));
        vecs.push_back(mk(0, 6'b000011, 0, 6'b000001, 0, 0, 1));
        vecs.push_back(mk(0, 6'b000011, 0, 6'b000001, 1, 0, 1));
        vecs.push_back(mk(0, 6'b000011, 0, 6'b000001, 1, 0, 1));
        vecs.push_back(mk(0, 6'b000011, 0, 6'b000001, 1, 0, 1));
        vecs.push_back(mk(0, 6'b000010, 0, 6'b000010, 1, 0, 1));
        vecs.push_back(mk(0, 6'b000011, 1, 6'b000000, 1, 1, 1));
        vecs.push_back(mk(0, 6'b000000, 0, 6'b000000, 0, 0, 0));
`endif

        foreach (vecs[n]) begin
            vec_t v;
            string tag;
            v = vecs[n];
            reset = v.rst; req = v.req; pause = v.pause;
            #1;
            tag = $sformatf("v%0d", n);
            chk({tag, " gnt"}, 32'(gnt), 32'(v.exp_gnt));
            @(posedge clock);
            #1;
            chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'(v.exp_vld));
            chk({tag, " busy"}, 32'(busy), 32'(v.exp_busy));
            if (v.exp_vld) begin
                chk({tag, " rsp_id"}, 32'(rsp_id), 32'(v.exp_id));
                chk({tag, " rsp_data"}, 32'(rsp_data),
                    32'(rom_f(spr_tab[v.exp_id], addr_tab[v.exp_id])));
            end else begin
                chk({tag, " rsp_data0"}, 32'(rsp_data), 32'd0);
            end
            if (v.rst) begin
                chk({tag, " rst rom_addr"}, 32'(rom_addr), 32'd0);
                chk({tag, " rst rom_sprite"}, 32'(rom_sprite), 32'd0);
                chk({tag, " rst rsp_id"}, 32'(rsp_id), 32'd0);
            end else if (v.exp_gnt != '0) begin
                for (int i = 0; i < N; i++) begin
                    if (v.exp_gnt[i]) begin
                        chk({tag, " rom_addr"}, 32'(rom_addr), 32'(addr_tab[i]));
                        chk({tag, " rom_sprite"}, 32'(rom_sprite), 32'(spr_tab[i]));
                    end
                end
            end
        end

        // Hand sequence: the first request after reset gives sprite 3,
        // addr 8'h45 and ROM data 2'b10, all as fixed constants.
        reset = 1'b1; req = '0; pause = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0; req = 6'b000001;
        #1 chk("seq gnt0", 32'(gnt), 32'h1);
        @(posedge clock); #1;
        req = '0;
        chk("seq rom_sprite", 32'(rom_sprite), 32'd3);
        chk("seq rom_addr", 32'(rom_addr), 32'h45);
        chk("seq not yet valid", 32'(rsp_valid), 32'd0);
        @(posedge clock); #1;
        chk("seq rsp_valid", 32'(rsp_valid), 32'd1);
        chk("seq rsp_id", 32'(rsp_id), 32'd0);
        chk("seq rsp_data", 32'(rsp_data), 32'b10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
